// File: rtl/s4ga_pkg.sv
// s4ga_pkg: shared types and derived-width helpers for the s4ga LUT evaluator.
//   seg_state_t  : config-stream FSM state (index fields vs. mask segments)
//   n_w_of       : LUT index width, wide enough for N LUTs plus NI primary inputs
//   idx_segs_of  : segments per index field
//   mask_segs_of : segments per LUT mask
//   k_w_of       : width of the per-LUT field counter (counts 0..K)
package s4ga_pkg;

  typedef enum logic {
    ST_IDX  = 1'b0,
    ST_MASK = 1'b1
  } seg_state_t;

  function automatic int n_w_of(input int n, input int ni);
    return $clog2(n + ni);
  endfunction

  function automatic int idx_segs_of(input int n_w, input int si_w);
    return (n_w + si_w - 1) / si_w;
  endfunction

  function automatic int mask_segs_of(input int k, input int si_w);
    return ((1 << k) + si_w - 1) / si_w;
  endfunction

  function automatic int k_w_of(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/s4ga_seg_fsm.sv
// s4ga_seg_fsm: sequences the config stream of one LUT: K index fields of
// IDX_SEGS segments each, then MASK_SEGS mask segments.
//   clk, rst    : clock, synchronous active-high reset
//   si_valid    : segment qualifier
//   seg_accept  : a segment is consumed this cycle
//   idx_done    : final segment of an index field consumed this cycle
//   mask_done   : final mask segment consumed this cycle (LUT evaluates)
module s4ga_seg_fsm
  import s4ga_pkg::*;
#(
  parameter int K         = 4,
  parameter int IDX_SEGS  = 2,
  parameter int MASK_SEGS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic si_valid,
  output logic seg_accept,
  output logic idx_done,
  output logic mask_done
);

  localparam int K_W     = k_w_of(K);
  localparam int SEG_MAX = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

  seg_state_t       state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [K_W-1:0]   k_q, k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDX;
      seg_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    k_d        = k_q;
    idx_done   = 1'b0;
    mask_done  = 1'b0;
    seg_accept = si_valid;
    if (si_valid) begin
      case (state_q)
        ST_IDX: begin
          if (seg_q == SEG_W'(IDX_SEGS - 1)) begin
            seg_d    = '0;
            k_d      = k_q + 1'b1;
            idx_done = 1'b1;
            if (k_q == K_W'(K - 1)) state_d = ST_MASK;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end
        ST_MASK: begin
          if (seg_q == SEG_W'(MASK_SEGS - 1)) begin
            seg_d     = '0;
            k_d       = '0;
            mask_done = 1'b1;
            state_d   = ST_IDX;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end
        default: state_d = ST_IDX;
      endcase
    end
  end

endmodule

// File: rtl/s4ga_x.sv
// s4ga_x: serial LUT evaluator. Each LUT arrives as a segmented config stream
// (K input indices, then a 2^K-bit truth mask); the result is shifted into a
// history register L, and at the end of each frame L is snapshotted into S.
//   clk, rst   : clock, synchronous active-high reset
//   si         : config segment, si_valid qualifies it
//   sync_mode  : 1 = LUT indices read the previous-frame snapshot S
//   ext_in     : primary inputs, addressed as indices N..N+NI-1
//   lut_out    : newest NO history bits, bit0 newest
//   lut_strobe : pulse, a LUT was evaluated
//   frame_done : pulse, LUT N-1 evaluated
//   frame_cnt  : completed frames, wrapping
module s4ga_x
  import s4ga_pkg::*;
#(
  parameter int N    = 16,
  parameter int K    = 4,
  parameter int SI_W = 4,
  parameter int NI   = 4,
  parameter int NO   = 8,
  parameter int FC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] si,
  input  logic            si_valid,
  input  logic            sync_mode,
  input  logic [NI-1:0]   ext_in,
  output logic [NO-1:0]   lut_out,
  output logic            lut_strobe,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int N_W       = n_w_of(N, NI);
  localparam int IDX_SEGS  = idx_segs_of(N_W, SI_W);
  localparam int MASK_SEGS = mask_segs_of(K, SI_W);
  localparam int M_BITS    = 1 << K;
  localparam int SH_W      = (N_W > M_BITS) ? N_W : M_BITS;
  localparam int NC_W      = $clog2(N);

  logic               seg_accept, idx_done, mask_done;
  logic [SH_W-1:0]    sh_q, sh_next;
  logic [N_W-1:0]     idx;
  logic [M_BITS-1:0]  mask;
  logic [N-1:0]       l_q, s_q, l_new;
  logic [K-1:0]       ins_q;
  logic [NC_W-1:0]    n_q;
  logic               in_bit, res;

  s4ga_seg_fsm #(
    .K        (K),
    .IDX_SEGS (IDX_SEGS),
    .MASK_SEGS(MASK_SEGS)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .si_valid  (si_valid),
    .seg_accept(seg_accept),
    .idx_done  (idx_done),
    .mask_done (mask_done)
  );

  // One shared MSB-first assembler serves both field types: the final segment
  // of a field always lands in the low bits, so the low N_W / 2^K bits of the
  // shifted value are exactly that field regardless of older contents.
  assign sh_next = SH_W'({sh_q, si});
  assign idx     = sh_next[N_W-1:0];
  assign mask    = sh_next[M_BITS-1:0];

  // Index resolution: history/snapshot, then primary inputs, else constant 0.
  always_comb begin
    in_bit = 1'b0;
    for (int j = 0; j < N; j++)
      if (int'(idx) == j) in_bit = sync_mode ? s_q[j] : l_q[j];
    for (int j = 0; j < NI; j++)
      if (int'(idx) == N + j) in_bit = ext_in[j];
  end

  always_comb begin
    res = 1'b0;
    for (int j = 0; j < M_BITS; j++)
      if (int'(ins_q) == j) res = mask[j];
  end

  assign l_new = {l_q[N-2:0], res};

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      ins_q      <= '0;
      l_q        <= '0;
      s_q        <= '0;
      n_q        <= '0;
      lut_out    <= '0;
      lut_strobe <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      lut_strobe <= 1'b0;
      frame_done <= 1'b0;
      if (seg_accept) sh_q <= sh_next;
      // First-resolved input ends up as the MSB of ins after K shifts.
      if (idx_done) ins_q <= K'({ins_q, in_bit});
      if (mask_done) begin
        l_q        <= l_new;
        lut_out    <= l_new[NO-1:0];
        lut_strobe <= 1'b1;
        if (n_q == NC_W'(N - 1)) begin
          n_q        <= '0;
          s_q        <= l_new;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 1'b1;
        end else begin
          n_q <= n_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s4ga_x.sv
// tb_s4ga_x: scoreboard bench for s4ga_x (N=16, K=4, SI_W=4, NI=4, NO=8).
// Stimulus pushes the expected strobe contents and cycle into exp_q; the
// monitor pops and compares whenever lut_strobe is seen.
module tb_s4ga_x;
  localparam int N = 16, K = 4, SI_W = 4, NI = 4, NO = 8, FC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SI_W-1:0] si = '0;
  logic            si_valid = 1'b0;
  logic            sync_mode = 1'b0;
  logic [NI-1:0]   ext_in = '0;
  logic [NO-1:0]   lut_out;
  logic            lut_strobe, frame_done;
  logic [FC_W-1:0] frame_cnt;

  s4ga_x #(.N(N), .K(K), .SI_W(SI_W), .NI(NI), .NO(NO), .FC_W(FC_W)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .sync_mode(sync_mode),
    .ext_in(ext_in), .lut_out(lut_out), .lut_strobe(lut_strobe),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic       fd;
    logic [7:0] fc;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  // reference model state
  logic [15:0] lm = '0, sm = '0;
  int          nm = 0;
  logic [7:0]  fcm = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic res_idx(input logic [4:0] i, input logic sy);
    if (i < 5'd16) return sy ? sm[i[3:0]] : lm[i[3:0]];
    if (i < 5'd20) return ext_in[i[1:0]];
    return 1'b0;
  endfunction

  // Drive one full LUT config; gap=1 inserts an idle cycle before each segment.
  task automatic send_lut(input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2,
                          input logic [4:0] i3, input logic [15:0] mask, input logic sy,
                          input bit gap);
    logic [3:0] ins;
    logic       r;
    logic [3:0] segs [12];
    exp_t       e;
    ins = {res_idx(i0, sy), res_idx(i1, sy), res_idx(i2, sy), res_idx(i3, sy)};
    r   = mask[ins];
    lm  = {lm[14:0], r};
    e.lo = lm[7:0];
    e.fd = (nm == N - 1);
    if (nm == N - 1) begin sm = lm; fcm = fcm + 8'd1; nm = 0; end
    else nm++;
    e.fc = fcm;
    segs = '{{3'b0, i0[4]}, i0[3:0], {3'b0, i1[4]}, i1[3:0],
             {3'b0, i2[4]}, i2[3:0], {3'b0, i3[4]}, i3[3:0],
             mask[15:12], mask[11:8], mask[7:4], mask[3:0]};
    sync_mode = sy;
    for (int j = 0; j < 12; j++) begin
      if (gap) begin @(negedge clk); si_valid = 1'b0; si = ~segs[j]; end
      @(negedge clk); si = segs[j]; si_valid = 1'b1;
      if (j == 11) begin e.due = cyc + 1; exp_q.push_back(e); end
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    @(negedge clk); si_valid = 1'b0;
    while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    chk(tag, exp_q.size(), 0);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (lut_strobe === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.due);
        chk("lut_out", lut_out, e.lo);
        chk("frame_done", frame_done, e.fd);
        chk("frame_cnt", frame_cnt, e.fc);
      end
    end else if (frame_done !== 1'b0) begin
      chk("frame_done_without_strobe", frame_done, 0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_lut_out", lut_out, 0);
    chk("rst_lut_strobe", lut_strobe, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;

    // LUT0: all indices 0x1F -> ins=0000, mask FFFF -> 1, lut_out 0x01
    send_lut(5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 1'b0);
    // ext_in[0]=1 on all four fields -> ins=1111, mask 8000 -> 1, lut_out 0x03
    ext_in = 4'b0001;
    send_lut(5'd16, 5'd16, 5'd16, 5'd16, 16'h8000, 1'b0, 1'b0);
    // same with ext_in=0 -> ins=0000 -> 0, lut_out 0x06
    ext_in = 4'b0000;
    send_lut(5'd16, 5'd16, 5'd16, 5'd16, 16'h8000, 1'b0, 1'b0);
    // toggled si_valid -> 1, lut_out 0x0D, strobe after 12th accepted segment
    ext_in = 4'b0001;
    send_lut(5'd16, 5'd16, 5'd16, 5'd16, 16'h8000, 1'b0, 1'b1);
    drain("drain_directed");

    // finish frame 1 with mask AAAA, index3=0: result follows L[0]
    for (int j = 0; j < 12; j++) send_lut(5'h1F, 5'h1F, 5'h1F, 5'd0, 16'hAAAA, 1'b0, 1'b0);
    // frame 2: inverted copy of index 0, alternating between L and S sources
    for (int j = 0; j < 16; j++) send_lut(5'h1F, 5'h1F, 5'h1F, 5'd0, 16'h5555, j[0], 1'b0);
    drain("drain_frames");

    // 255 more frames: 2 + 255 = 257 -> frame_cnt wraps to 1
    for (int f = 0; f < 255; f++)
      for (int j = 0; j < 16; j++) send_lut(5'h1F, 5'h1F, 5'h1F, 5'd0, 16'hAAAA, 1'b0, 1'b0);
    drain("drain_wrap");
    chk("frame_cnt_wrap", frame_cnt, 1);

    // reset mid-LUT: LUTs 0..2 -> lut_out 0x07, then 7 segments of LUT 3
    for (int j = 0; j < 3; j++) send_lut(5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 1'b0);
    for (int j = 0; j < 7; j++) begin @(negedge clk); si = 4'h1; si_valid = 1'b1; end
    drain("drain_pre_rst");
    chk("pre_rst_lut_out", lut_out, 8'h07);
    @(negedge clk); rst = 1'b1; si_valid = 1'b1; si = 4'hF;
    @(negedge clk); rst = 1'b0; si_valid = 1'b0;
    chk("mid_rst_lut_out", lut_out, 0);
    chk("mid_rst_lut_strobe", lut_strobe, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    lm = '0; sm = '0; nm = 0; fcm = '0;
    // fresh LUT 0 -> lut_out 0x01, then a full frame ending at frame_cnt=1
    send_lut(5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 1'b0);
    for (int j = 0; j < 15; j++) send_lut(5'h1F, 5'h1F, 5'h1F, 5'd0, 16'hAAAA, 1'b0, 1'b0);
    drain("drain_post_rst");
    chk("post_rst_frame_cnt", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s4ga_x.md
S4GA_X -- requirements
Module: s4ga_x

Interface
REQ-001 SHALL have parameter N, default 16: number of LUTs per frame, N>=2.
REQ-002 SHALL have parameter K, default 4: number of LUT inputs, 1..6.
REQ-003 SHALL have parameter SI_W, default 4: config stream segment width.
REQ-004 SHALL have parameter NI, default 4: number of external primary inputs.
REQ-005 SHALL have parameter NO, default 8: number of exported LUT outputs, NO<=N.
REQ-006 SHALL have parameter FC_W, default 8: frame counter width.
REQ-007 SHALL have ports, clock and reset first:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  si  in  SI_W  config segment
  si_valid  in  1  segment qualifier
  sync_mode  in  1  1 = inputs read from the previous-frame snapshot
  ext_in  in  NI  primary inputs
  lut_out  out  NO  most recent NO LUT outputs, bit0 newest
  lut_strobe  out  1  pulse: a LUT was evaluated
  frame_done  out  1  pulse: LUT N-1 evaluated
  frame_cnt  out  FC_W  completed frames, wraps

Function
REQ-008 SHALL use N_W=clog2(N+NI), IDX_SEGS=ceil(N_W/SI_W), MASK_SEGS=ceil(2^K/SI_W).
REQ-009 SHALL receive each LUT config as K index fields of IDX_SEGS segments each, followed by MASK_SEGS mask segments; within a field the first segment is most significant, and only the low N_W (resp. 2^K) bits are used.
REQ-010 SHALL accept a segment only in cycles with si_valid=1; cycles with si_valid=0 SHALL leave all state and outputs unchanged, except that the pulse outputs drop to 0.
REQ-011 SHALL maintain an N-bit LUT history shift register L: each evaluation shifts the result into L[0].
REQ-012 SHALL resolve index i on the final segment of an index field as follows:
  - i<N: L[i] when sync_mode=0, S[i] when sync_mode=1;
  - N<=i<N+NI: ext_in[i-N];
  - i>=N+NI: 0.
REQ-013 SHALL shift each resolved input into a K-bit register ins at bit0, so the first-loaded input is the MSB.
REQ-014 SHALL compute the LUT result as mask[ins] when the final mask segment is accepted.
REQ-015 SHALL register lut_strobe=1 in the following cycle, and update lut_out=L[NO-1:0] in that same cycle.
REQ-016 SHALL track the LUT counter n in [0,N-1]; on evaluating n=N-1 it SHALL wrap to 0, copy the updated L into snapshot S, pulse frame_done, and increment frame_cnt modulo 2^FC_W.
REQ-017 SHALL sample sync_mode per index resolution; changing it mid-frame takes effect at the next index field.
REQ-018 SHALL implement a control FSM with states IDX (k<K) and MASK (k==K), a segment counter, and a k counter; IDX->MASK after K fields, and MASK->IDX after MASK_SEGS segments.
REQ-019 SHALL make lut_strobe and frame_done single-cycle pulses, never asserted in consecutive cycles for N>=2.

Reset
REQ-020 SHALL, when rst=1, set the following in one cycle:
  - L, S, ins, n, k, segment counter, shift register: 0;
  - lut_out: 0; lut_strobe: 0; frame_done: 0; frame_cnt: 0.
REQ-021 SHALL give rst priority over si_valid; rst mid-LUT SHALL discard the partial config, and the next accepted segment is index 0 segment 0 of LUT 0.
REQ-022 SHALL require no multi-cycle reset hold, unlike the serial-shift clear scheme.

Structure
REQ-023 SHALL place the derived widths N_W, IDX_SEGS, MASK_SEGS, K_W and the FSM state enum in shared package s4ga_pkg.
REQ-024 SHALL have one sub-module, s4ga_seg_fsm, containing the k and segment counters and FSM, and emitting idx_done, mask_done and the segment-accept signal; the datapath stays in s4ga_x.

Verification
Bench parameters: N=16, K=4, SI_W=4, NI=4, NO=8, giving N_W=5, IDX_SEGS=2, MASK_SEGS=4, and 12 segments per LUT.
REQ-025 SHALL cover mask 0xFFFF for LUT 0, with all indices 0x1F -> lut_strobe one cycle after the 12th segment, and lut_out=0x01.
REQ-026 SHALL cover ext_in=0b0001, four indices =16 (0x10), and mask 0x8000 -> ins=4'b1111, LUT=1; repeating with ext_in=0 -> LUT=0.
REQ-027 SHALL cover si_valid toggled 0/1 every cycle over one LUT -> same result as the contiguous stream, with strobe only after the 12th accepted segment.
REQ-028 SHALL cover 16 LUTs, each with mask 0xAAAA and index[3]=0 -> frame_done pulse after LUT 15, frame_cnt=1, and S equal to L; a further 256 frames -> frame_cnt wraps to 1.
REQ-029 SHALL cover sync_mode=1 vs 0 on the same second-frame stream reading index 0 -> results differ exactly where L[0] differs from S[0].
REQ-030 SHALL cover rst asserted for one cycle after the 7th segment of LUT 3 -> all outputs 0 next cycle, and the subsequent 12 segments evaluate as LUT 0.
